// File: rtl/icache_fill_responder.sv
// icache_fill_responder
//   Memory-side responder for the cache miss bus, standing in for the SDR
//   controller. A strobed read returns an aligned burst of BURST_LEN
//   halfwords from a fixed-latency SRAM. A strobed write stores one halfword.
//
// Ports
//   Clk, Reset                  clock and synchronous active-high reset
//   MStrobe/MRW/MAddress/MDataIn request from the cache (sampled in IDLE only)
//   MDataOut/mSDR_RxD           read beat data and its valid pulse
//   mSDR_TxD                    write committed pulse
//   MGrant                      request accepted / transfer in progress
//   SramAddr/SramRd/SramWr/
//   SramWData/SramRData         backing SRAM port; read data arrives
//                               SRAM_LAT cycles after SramRd
module icache_fill_responder #(
  parameter int BURST_LEN = 4,
  parameter int SRAM_LAT  = 2,
  parameter int ADDR_W    = 18
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [31:0]       MAddress,
  input  logic [31:0]       MDataIn,
  output logic [31:0]       MDataOut,
  output logic              MGrant,
  output logic              mSDR_RxD,
  output logic              mSDR_TxD,
  output logic [ADDR_W-1:0] SramAddr,
  output logic              SramRd,
  output logic              SramWr,
  output logic [15:0]       SramWData,
  input  logic [15:0]       SramRData
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BURST_LEN - 1));
  // Pipe contents when only the final in-flight read remains.
  localparam logic [SRAM_LAT:1] LAST_ONLY  = SRAM_LAT'(1) << (SRAM_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, waddr_q;
  logic [15:0]       wdata_q;
  // vld_pipe_q[i] is SramRd delayed by i cycles; the top bit marks a beat.
  logic [SRAM_LAT:1] vld_pipe_q;

  logic unused_hi;
  assign unused_hi = ^{MAddress[31:ADDR_W], MDataIn[31:16]};

  wire accept = (state_q == IDLE) && MStrobe;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      vld_pipe_q[1] <= SramRd;
      for (int i = 2; i <= SRAM_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      if (accept) begin
        base_q  <= MAddress[ADDR_W-1:0] & ALIGN_MASK;
        waddr_q <= MAddress[ADDR_W-1:0];
        wdata_q <= MDataIn[15:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    MGrant    = 1'b0;
    SramRd    = 1'b0;
    SramWr    = 1'b0;
    SramAddr  = '0;
    SramWData = '0;
    mSDR_TxD  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (MStrobe) state_d = MRW ? READ : WRITE;
      end
      READ: begin
        MGrant   = 1'b1;
        SramRd   = 1'b1;
        // base is aligned, so adding the beat index only fills the low bits.
        SramAddr = base_q + ADDR_W'(cnt_q);
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BEAT) state_d = DRAIN;
      end
      DRAIN: begin
        MGrant = 1'b1;
        // Reads were issued contiguously, so a lone top bit is the last beat.
        if (vld_pipe_q == LAST_ONLY) state_d = IDLE;
      end
      WRITE: begin
        MGrant    = 1'b1;
        SramWr    = 1'b1;
        SramAddr  = waddr_q;
        SramWData = wdata_q;
        mSDR_TxD  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mSDR_RxD = vld_pipe_q[SRAM_LAT];
  assign MDataOut = mSDR_RxD ? {SramRData, SramRData} : 32'h0;

endmodule

// File: tb/tb_icache_fill_responder.sv
module tb_icache_fill_responder;

  logic        Clk, Reset, MRW;
  logic [31:0] MAddress, MDataIn;
  int          total, passed;

  // Instance A: BURST_LEN=4, SRAM_LAT=2
  logic        a_stb, a_grant, a_rxd, a_txd, a_rd, a_wr;
  logic [31:0] a_dout;
  logic [17:0] a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic [15:0] a_dp [1:2];
  // Single-entry write record layered over the a+0x1000 preload.
  logic        wr_vld;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;

  // Instance B: BURST_LEN=1, SRAM_LAT=1
  logic        b_stb, b_grant, b_rxd, b_txd, b_rd, b_wr;
  logic [31:0] b_dout;
  logic [17:0] b_addr;
  logic [15:0] b_wdata, b_rdata;

  // Instance C: BURST_LEN=8, SRAM_LAT=4
  logic        c_stb, c_grant, c_rxd, c_txd, c_rd, c_wr;
  logic [31:0] c_dout;
  logic [17:0] c_addr;
  logic [15:0] c_wdata, c_rdata;
  logic [15:0] c_dp [1:4];

  logic [70:0] a_obs, b_obs, c_obs;
  assign a_obs = {a_grant, a_rd, a_wr, a_rxd, a_txd, a_addr, a_wdata, a_dout};
  assign b_obs = {b_grant, b_rd, b_wr, b_rxd, b_txd, b_addr, b_wdata, b_dout};
  assign c_obs = {c_grant, c_rd, c_wr, c_rxd, c_txd, c_addr, c_wdata, c_dout};

  icache_fill_responder #(.BURST_LEN(4), .SRAM_LAT(2), .ADDR_W(18)) u_a (
    .Clk(Clk), .Reset(Reset), .MStrobe(a_stb), .MRW(MRW), .MAddress(MAddress),
    .MDataIn(MDataIn), .MDataOut(a_dout), .MGrant(a_grant), .mSDR_RxD(a_rxd),
    .mSDR_TxD(a_txd), .SramAddr(a_addr), .SramRd(a_rd), .SramWr(a_wr),
    .SramWData(a_wdata), .SramRData(a_rdata));

  icache_fill_responder #(.BURST_LEN(1), .SRAM_LAT(1), .ADDR_W(18)) u_b (
    .Clk(Clk), .Reset(Reset), .MStrobe(b_stb), .MRW(MRW), .MAddress(MAddress),
    .MDataIn(MDataIn), .MDataOut(b_dout), .MGrant(b_grant), .mSDR_RxD(b_rxd),
    .mSDR_TxD(b_txd), .SramAddr(b_addr), .SramRd(b_rd), .SramWr(b_wr),
    .SramWData(b_wdata), .SramRData(b_rdata));

  icache_fill_responder #(.BURST_LEN(8), .SRAM_LAT(4), .ADDR_W(18)) u_c (
    .Clk(Clk), .Reset(Reset), .MStrobe(c_stb), .MRW(MRW), .MAddress(MAddress),
    .MDataIn(MDataIn), .MDataOut(c_dout), .MGrant(c_grant), .mSDR_RxD(c_rxd),
    .mSDR_TxD(c_txd), .SramAddr(c_addr), .SramRd(c_rd), .SramWr(c_wr),
    .SramWData(c_wdata), .SramRData(c_rdata));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM models: data for the address seen at a rising edge appears
  // SRAM_LAT cycles later.
  always @(posedge Clk) begin
    a_dp[1] <= (wr_vld && wr_addr == a_addr) ? wr_data : a_addr[15:0] + 16'h1000;
    a_dp[2] <= a_dp[1];
    if (Reset) wr_vld <= 1'b0;
    else if (a_wr) begin
      wr_vld  <= 1'b1;
      wr_addr <= a_addr;
      wr_data <= a_wdata;
    end
    b_rdata <= b_addr[15:0] + 16'h1000;
    c_dp[1] <= c_addr[15:0] + 16'h1000;
    for (int i = 2; i <= 4; i++) c_dp[i] <= c_dp[i-1];
  end
  assign a_rdata = a_dp[2];
  assign c_rdata = c_dp[4];

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    total++; if (a_obs !== 71'h0) $display("FAIL reset_a: got %h exp %h", a_obs, 71'h0); else passed++;
    total++; if (b_obs !== 71'h0) $display("FAIL reset_b: got %h exp %h", b_obs, 71'h0); else passed++;
    total++; if (c_obs !== 71'h0) $display("FAIL reset_c: got %h exp %h", c_obs, 71'h0); else passed++;
    Reset = 1'b0;
    tick();
    total++; if (a_obs !== 71'h0) $display("FAIL idle_a: got %h exp %h", a_obs, 71'h0); else passed++;
  endtask

  task automatic test_read_burst();
    logic [70:0] e;
    logic g, rd, rx;
    logic [17:0] ad;
    logic [15:0] h;
    a_stb = 1'b1; MRW = 1'b1; MAddress = 32'h105;
    tick();
    a_stb = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      g = (c <= 6); rd = (c <= 4); rx = (c >= 3 && c <= 6);
      ad = rd ? 18'h104 + 18'(c - 1) : 18'h0;
      h = 16'h1104 + 16'(c - 3);
      e = {g, rd, 1'b0, rx, 1'b0, ad, 16'h0, rx ? {h, h} : 32'h0};
      total++; if (a_obs !== e) $display("FAIL read_burst c%0d: got %h exp %h", c, a_obs, e); else passed++;
      tick();
    end
  endtask

  task automatic test_write();
    logic [70:0] e;
    logic g, rd, rx;
    logic [17:0] ad;
    logic [15:0] h;
    a_stb = 1'b1; MRW = 1'b0; MAddress = 32'h2A3; MDataIn = 32'hDEADBEEF;
    tick();
    a_stb = 1'b0; MDataIn = 32'h0;
    e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 18'h2A3, 16'hBEEF, 32'h0};
    total++; if (a_obs !== e) $display("FAIL write_c1: got %h exp %h", a_obs, e); else passed++;
    tick();
    total++; if (a_obs !== 71'h0) $display("FAIL write_c2: got %h exp %h", a_obs, 71'h0); else passed++;
    // Read back immediately; the written halfword is offset 3 of block 0x2A0.
    a_stb = 1'b1; MRW = 1'b1; MAddress = 32'h2A3;
    tick();
    a_stb = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      g = (c <= 6); rd = (c <= 4); rx = (c >= 3 && c <= 6);
      ad = rd ? 18'h2A0 + 18'(c - 1) : 18'h0;
      h = (c == 6) ? 16'hBEEF : 16'h12A0 + 16'(c - 3);
      e = {g, rd, 1'b0, rx, 1'b0, ad, 16'h0, rx ? {h, h} : 32'h0};
      total++; if (a_obs !== e) $display("FAIL write_readback c%0d: got %h exp %h", c, a_obs, e); else passed++;
      tick();
    end
  endtask

  task automatic test_strobe_busy();
    logic [70:0] e;
    logic g, rd, rx;
    logic [17:0] ad;
    logic [15:0] h;
    a_stb = 1'b1; MRW = 1'b1; MAddress = 32'h41;
    tick();
    a_stb = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      g = (c <= 6); rd = (c <= 4); rx = (c >= 3 && c <= 6);
      ad = rd ? 18'h40 + 18'(c - 1) : 18'h0;
      h = 16'h1040 + 16'(c - 3);
      e = {g, rd, 1'b0, rx, 1'b0, ad, 16'h0, rx ? {h, h} : 32'h0};
      total++; if (a_obs !== e) $display("FAIL strobe_busy c%0d: got %h exp %h", c, a_obs, e); else passed++;
      if (c == 3) begin
        a_stb = 1'b1; MRW = 1'b0; MAddress = 32'h3FF; MDataIn = 32'h5555;
      end else if (c == 4) begin
        a_stb = 1'b0; MDataIn = 32'h0;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [70:0] e;
    logic g, rd, rx;
    logic [17:0] ad;
    logic [15:0] h;
    a_stb = 1'b1; MRW = 1'b1; MAddress = 32'h80;
    tick();
    a_stb = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      rd = 1'b1; rx = (c >= 3);
      ad = 18'h80 + 18'(c - 1);
      h = 16'h1080 + 16'(c - 3);
      e = {1'b1, rd, 1'b0, rx, 1'b0, ad, 16'h0, rx ? {h, h} : 32'h0};
      total++; if (a_obs !== e) $display("FAIL reset_mid_pre c%0d: got %h exp %h", c, a_obs, e); else passed++;
      if (c == 4) Reset = 1'b1;
      tick();
    end
    Reset = 1'b0;
    total++; if (a_obs !== 71'h0) $display("FAIL reset_mid_c5: got %h exp %h", a_obs, 71'h0); else passed++;
    tick();
    total++; if (a_obs !== 71'h0) $display("FAIL reset_mid_c6: got %h exp %h", a_obs, 71'h0); else passed++;
    a_stb = 1'b1; MRW = 1'b1; MAddress = 32'hC6;
    tick();
    a_stb = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      g = (c <= 6); rd = (c <= 4); rx = (c >= 3 && c <= 6);
      ad = rd ? 18'hC4 + 18'(c - 1) : 18'h0;
      h = 16'h10C4 + 16'(c - 3);
      e = {g, rd, 1'b0, rx, 1'b0, ad, 16'h0, rx ? {h, h} : 32'h0};
      total++; if (a_obs !== e) $display("FAIL reset_mid_fresh c%0d: got %h exp %h", c, a_obs, e); else passed++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [70:0] e;
    logic g, rd, rx;
    logic [17:0] ad;
    logic [15:0] h;
    a_stb = 1'b1; MRW = 1'b1; MAddress = 32'h13;
    tick();
    a_stb = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      g = (c <= 6); rd = (c <= 4); rx = (c >= 3 && c <= 6);
      ad = rd ? 18'h10 + 18'(c - 1) : 18'h0;
      h = 16'h1010 + 16'(c - 3);
      e = {g, rd, 1'b0, rx, 1'b0, ad, 16'h0, rx ? {h, h} : 32'h0};
      total++; if (a_obs !== e) $display("FAIL b2b_first c%0d: got %h exp %h", c, a_obs, e); else passed++;
      if (c == 7) begin
        a_stb = 1'b1; MAddress = 32'h21;
      end
      tick();
    end
    a_stb = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      g = (c <= 6); rd = (c <= 4); rx = (c >= 3 && c <= 6);
      ad = rd ? 18'h20 + 18'(c - 1) : 18'h0;
      h = 16'h1020 + 16'(c - 3);
      e = {g, rd, 1'b0, rx, 1'b0, ad, 16'h0, rx ? {h, h} : 32'h0};
      total++; if (a_obs !== e) $display("FAIL b2b_second c%0d: got %h exp %h", c, a_obs, e); else passed++;
      tick();
    end
  endtask

  task automatic test_param_sweep();
    logic [70:0] e;
    logic g, rd, rx;
    logic [17:0] ad;
    logic [15:0] h;
    b_stb = 1'b1; MRW = 1'b1; MAddress = 32'h10;
    tick();
    b_stb = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      g = (c <= 2); rd = (c == 1); rx = (c == 2);
      ad = rd ? 18'h10 : 18'h0;
      e = {g, rd, 1'b0, rx, 1'b0, ad, 16'h0, rx ? 32'h10101010 : 32'h0};
      total++; if (b_obs !== e) $display("FAIL sweep_b1l1 c%0d: got %h exp %h", c, b_obs, e); else passed++;
      tick();
    end
    c_stb = 1'b1; MRW = 1'b1; MAddress = 32'h0F;
    tick();
    c_stb = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      g = (c <= 12); rd = (c <= 8); rx = (c >= 5 && c <= 12);
      ad = rd ? 18'h08 + 18'(c - 1) : 18'h0;
      h = 16'h1008 + 16'(c - 5);
      e = {g, rd, 1'b0, rx, 1'b0, ad, 16'h0, rx ? {h, h} : 32'h0};
      total++; if (c_obs !== e) $display("FAIL sweep_b8l4 c%0d: got %h exp %h", c, c_obs, e); else passed++;
      tick();
    end
  endtask

  initial begin
    total = 0; passed = 0;
    Reset = 1'b1; MRW = 1'b0; MAddress = 32'h0; MDataIn = 32'h0;
    a_stb = 1'b0; b_stb = 1'b0; c_stb = 1'b0;
    test_reset();
    test_read_burst();
    test_write();
    test_strobe_busy();
    test_reset_mid();
    test_back_to_back();
    test_param_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/icache_fill_responder.md
Name: icache_fill_responder

Overview:
Memory-side responder for the synchronous memory bus driven by the instruction/data cache miss logic. It accepts a strobed request from the cache. For a read, it returns an aligned burst of BURST_LEN halfwords fetched from a fixed-latency backing SRAM, pulsing mSDR_RxD per beat. For a write, it performs a single halfword store and pulses mSDR_TxD. It sits between the cache's memory port and the board SRAM and stands in for the SDR controller.

Parameters:
BURST_LEN, 4, halfword beats per read burst; power of two, legal values 1/2/4/8.
SRAM_LAT, 2, cycles from SramRd to valid SramRData; legal 1..4.
ADDR_W, 18, backing SRAM halfword address width.

Ports:
Clk  in  1  system clock, all logic on rising edge.
Reset  in  1  synchronous, active-high reset.
MStrobe  in  1  request strobe, sampled only in IDLE.
MRW  in  1  1 = read burst, 0 = single write.
MAddress  in  32  halfword address; bits [ADDR_W-1:0] used.
MDataIn  in  32  write data; [15:0] stored.
MDataOut  out  32  read beat, halfword replicated {h,h}; zero when mSDR_RxD=0.
MGrant  out  1  request accepted / transfer in progress.
mSDR_RxD  out  1  read beat valid on MDataOut.
mSDR_TxD  out  1  write beat committed.
SramAddr  out  ADDR_W  backing SRAM address.
SramRd  out  1  SRAM read issue.
SramWr  out  1  SRAM write enable.
SramWData  out  16  SRAM write data.
SramRData  in  16  SRAM read data, valid SRAM_LAT cycles after SramRd.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, port name Reset.
- Reset: state IDLE. All outputs 0: MGrant, mSDR_RxD, mSDR_TxD, SramRd, SramWr, MDataOut, SramAddr, SramWData. Read-return valid pipeline is cleared.
- FSM states: IDLE, READ, DRAIN, WRITE.
- IDLE, MStrobe=1 at cycle 0:
  - Latch base = MAddress[ADDR_W-1:0] with the low log2(BURST_LEN) bits cleared.
  - Latch the write address unaligned, and MDataIn[15:0].
  - Next state READ if MRW=1, else WRITE.
- MStrobe while MGrant=1 is ignored. MRW, MAddress and MDataIn are don't-care outside the accept cycle.
- READ:
  - Starts at cycle 1. MGrant=1.
  - SramRd=1 with SramAddr = base + k for k = 0..BURST_LEN-1, one per cycle, back-to-back, ascending. The low index bits are k, so the burst never crosses block alignment.
  - After issuing k = BURST_LEN-1, go to DRAIN.
- Return pipeline: an SRAM_LAT-deep valid shift register, fed by SramRd.
  - When a valid emerges: mSDR_RxD=1 and MDataOut = {SramRData, SramRData}.
  - Beat k appears at cycle 1 + k + SRAM_LAT. The last beat appears at cycle BURST_LEN + SRAM_LAT.
- DRAIN: MGrant=1 and SramRd=0. Leave to IDLE after the last beat is returned. MGrant is 0 the cycle after the last beat.
- WRITE:
  - Cycle 1: MGrant=1, SramWr=1, SramAddr = latched address, SramWData = latched data, mSDR_TxD=1. All for one cycle.
  - Cycle 2: IDLE, MGrant=0.
- Back-to-back: earliest new accept is the first cycle MGrant=0, i.e. the cycle after the last beat or the write.
- SramRd and SramWr are never high together.
- mSDR_RxD and mSDR_TxD are single-cycle pulses.
- Reset mid-operation: outputs go to their reset values on the next edge. In-flight SRAM returns are discarded, with no stray mSDR_RxD.
- BURST_LEN=1: READ issues one read, then goes to DRAIN.

Test Plan:
- Read, LAT=2, BURST_LEN=4: preload mem[a] = a + 0x1000, MStrobe/MRW=1, MAddress=0x105 at cycle 0 -> SramAddr 0x104..0x107 on cycles 1-4. mSDR_RxD on cycles 3-6 with MDataOut 0x11041104, 0x11051105, 0x11061106, 0x11071107. MGrant high cycles 1-6, low at cycle 7.
- Write: MRW=0, MAddress=0x2A3, MDataIn=0xDEADBEEF -> cycle 1: SramWr=1, SramAddr=0x2A3, SramWData=0xBEEF, mSDR_TxD=1. MGrant low at cycle 2. A following read of 0x2A3 returns 0xBEEFBEEF at the beat for offset 3.
- Strobe while busy: second MStrobe (MRW=0) on cycle 3 of a read -> ignored, no SramWr, burst completes unchanged.
- Reset mid-burst: Reset=1 at cycle 4 -> cycle 5 all outputs 0, no mSDR_RxD pulses afterwards. A fresh read at cycle 6 returns 4 correct beats.
- Back-to-back: new read strobed on the first MGrant=0 cycle after a burst -> accepted, SramRd next cycle, 4 beats.
- Parameter sweep: BURST_LEN=1, LAT=1, MAddress=0x10 -> one beat at cycle 2 with 0x10101010, MGrant low at cycle 3. BURST_LEN=8, LAT=4, MAddress=0x0F -> addresses 0x08..0x0F, 8 beats on cycles 5-12.
